// File: rtl/fetch_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared definitions for the fetch sequencer: opcode constants, FSM state
//   encoding and the decode-stage dispatch helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package fetch_sequencer_pkg;

   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned STATE_W  = 3;

   localparam logic [OPCODE_W-1:0] OP_NOP   = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_STORE = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_JMP   = 4'h8;
   localparam logic [OPCODE_W-1:0] OP_HALT  = 4'hF;

   localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] S_FETCH    = 3'd1;
   localparam logic [STATE_W-1:0] S_DECODE   = 3'd2;
   localparam logic [STATE_W-1:0] S_EXEC_MEM = 3'd3;
   localparam logic [STATE_W-1:0] S_EXEC     = 3'd4;
   localparam logic [STATE_W-1:0] S_HALT     = 3'd5;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = S_IDLE,
      ST_FETCH    = S_FETCH,
      ST_DECODE   = S_DECODE,
      ST_EXEC_MEM = S_EXEC_MEM,
      ST_EXEC     = S_EXEC,
      ST_HALT     = S_HALT
   } state_e;

   // State entered after DECODE; unknown opcodes run as NOP through EXEC.
   function automatic state_e decode_next(input logic [OPCODE_W-1:0] op);
      state_e nxt;
      case (op)
         OP_HALT:           nxt = ST_HALT;
         OP_LOAD, OP_STORE: nxt = ST_EXEC_MEM;
         OP_NOP:            nxt = ST_EXEC;
         default:           nxt = ST_EXEC;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
//   Memory-side bus of the fetch sequencer.
//   fetch      : 1 = instruction fetch cycle (downstream mux selects pcout)
//   pcout      : program counter
//   irout      : address field of the instruction register
//   mem_req    : memory request active
//   mem_we     : write request
//   mem_rdata  : memory read data
//   mem_ready  : memory completes the current request this cycle
// ----------------------------------------------------------------------------
interface fetch_sequencer_if #(
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned DATA_W = 32
);
   logic              fetch;
   logic [ADDR_W-1:0] pcout;
   logic [ADDR_W-1:0] irout;
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output fetch, pcout, irout, mem_req, mem_we,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  fetch, pcout, irout, mem_req, mem_we,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/fetch_sequencer_pc_reg.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_pc_reg
//   Program counter register: load, increment (wrapping) or hold.
//   clk, reset : clock, async active-high reset (loads RESET_PC)
//   load       : load load_val (priority over inc)
//   inc        : increment by one, modulo 2^ADDR_W
//   load_val   : value to load
//   pc         : current program counter
// ----------------------------------------------------------------------------
module fetch_sequencer_pc_reg #(
   parameter int unsigned           ADDR_W   = 28,
   parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_q;

   // Next PC; the add naturally wraps at ADDR_W bits.
   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_val;
      end else if (inc) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//   Owns the program counter and instruction register and sequences the
//   fetch/decode/execute cycle against a variable-latency memory.
//   clk, reset     : clock, async active-high reset
//   stall          : freeze state, PC and IR
//   branch_en      : taken branch, honoured only in EXEC
//   branch_target  : branch destination
//   mem            : memory-side bus (fetch/pcout/irout/mem_req/mem_we out,
//                    mem_rdata/mem_ready in)
//   opcode         : IR opcode field
//   ir_valid       : one-cycle pulse while in DECODE
//   halted         : HALT reached
// ----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 28,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                branch_en,
   input  logic [ADDR_W-1:0]   branch_target,
   fetch_sequencer_if.master   mem,
   output logic [OPCODE_W-1:0] opcode,
   output logic                ir_valid,
   output logic                halted
);

   state_e            state_d, state_q;
   logic [DATA_W-1:0] ir_d, ir_q;
   logic              fetch_d, fetch_q;
   logic              mem_req_d, mem_req_q;
   logic              mem_we_d, mem_we_q;
   logic              ir_valid_d, ir_valid_q;
   logic              halted_d, halted_q;

   logic              pc_load;
   logic              pc_inc;
   logic [ADDR_W-1:0] pc_load_val;
   logic [ADDR_W-1:0] pc;

   logic [OPCODE_W-1:0] ir_op;
   logic [ADDR_W-1:0]   ir_addr;

   assign ir_op   = ir_q[DATA_W-1 -: OPCODE_W];
   assign ir_addr = ir_q[ADDR_W-1:0];

   fetch_sequencer_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .reset    (reset),
      .load     (pc_load),
      .inc      (pc_inc),
      .load_val (pc_load_val),
      .pc       (pc)
   );

   // Next-state, IR and PC control; stall holds everything.
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      pc_load     = 1'b0;
      pc_inc      = 1'b0;
      pc_load_val = branch_target;

      if (!stall) begin
         case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
               if (mem.mem_ready) begin
                  ir_d    = mem.mem_rdata;
                  pc_inc  = 1'b1;
                  state_d = ST_DECODE;
               end
            end
            ST_DECODE: state_d = decode_next(ir_op);
            ST_EXEC_MEM: begin
               if (mem.mem_ready) begin
                  state_d = ST_FETCH;
               end
            end
            ST_EXEC: begin
               // JMP wins over a simultaneous taken branch.
               if (ir_op == OP_JMP) begin
                  pc_load     = 1'b1;
                  pc_load_val = ir_addr;
               end else if (branch_en) begin
                  pc_load     = 1'b1;
                  pc_load_val = branch_target;
               end
               state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
         endcase
      end

      // Outputs are registered copies of the decode of the next state.
      fetch_d    = (state_d == ST_FETCH);
      mem_req_d  = (state_d == ST_FETCH) || (state_d == ST_EXEC_MEM);
      mem_we_d   = (state_d == ST_EXEC_MEM) && (ir_d[DATA_W-1 -: OPCODE_W] == OP_STORE);
      ir_valid_d = (state_d == ST_DECODE);
      halted_d   = (state_d == ST_HALT);
   end

   // FSM, IR and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ir_q       <= '0;
         fetch_q    <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         fetch_q    <= fetch_d;
         mem_req_q  <= mem_req_d;
         mem_we_q   <= mem_we_d;
         ir_valid_q <= ir_valid_d;
         halted_q   <= halted_d;
      end
   end

   assign mem.fetch   = fetch_q;
   assign mem.pcout   = pc;
   assign mem.irout   = ir_addr;
   assign mem.mem_req = mem_req_q;
   assign mem.mem_we  = mem_we_q;
   assign opcode      = ir_op;
   assign ir_valid    = ir_valid_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer; each fetched word is queued with the
//   PC expected after the fetch and checked when the DUT decodes it.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   typedef struct packed {
      logic [27:0] pc;
      logic [31:0] ir;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_en;
   logic [27:0] branch_target;
   logic [3:0]  opcode;
   logic        ir_valid;
   logic        halted;

   int          checks   = 0;
   int          failures = 0;
   logic [27:0] pc_model;
   exp_t        sb_q[$];

   fetch_sequencer_if #(.ADDR_W(28), .DATA_W(32)) bus ();

   fetch_sequencer #(
      .ADDR_W   (28),
      .DATA_W   (32),
      .RESET_PC (28'h0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .mem           (bus),
      .opcode        (opcode),
      .ir_valid      (ir_valid),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fetch();
      int n = 0;
      while (bus.fetch !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("wait_fetch", 32'(bus.fetch), 32'd1);
   endtask

   // Called in DECODE: pop the oldest expectation and compare.
   task automatic decode_pop();
      exp_t e;
      check("decode_ir_valid", 32'(ir_valid), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check("decode_pc",     32'(bus.pcout), 32'(e.pc));
         check("decode_irout",  32'(bus.irout), 32'(e.ir[27:0]));
         check("decode_opcode", 32'(opcode),    32'(e.ir[31:28]));
      end
   endtask

   // Called in FETCH: hold off mem_ready for 'waits' cycles, then return word.
   task automatic fetch_instr(input logic [31:0] word, input int waits);
      exp_t e;
      check("fetch_pc", 32'(bus.pcout), 32'(pc_model));
      for (int i = 0; i < waits; i++) begin
         tick();
         check("fetch_wait_hold", {30'd0, bus.fetch, ir_valid}, 32'd2);
      end
      bus.mem_rdata = word;
      bus.mem_ready = 1'b1;
      pc_model      = pc_model + 28'd1;
      e.pc          = pc_model;
      e.ir          = word;
      sb_q.push_back(e);
      tick();
      bus.mem_ready = 1'b0;
      decode_pop();
   endtask

   initial begin
      exp_t e;
      reset         = 1'b1;
      stall         = 1'b0;
      branch_en     = 1'b0;
      branch_target = 28'h0;
      bus.mem_rdata = 32'h0;
      bus.mem_ready = 1'b0;
      pc_model      = 28'h0;

      // Reset state
      tick();
      tick();
      check("rst_ctrl", {27'd0, bus.fetch, bus.mem_req, bus.mem_we, ir_valid, halted}, 32'd0);
      check("rst_pcout", 32'(bus.pcout), 32'd0);
      check("rst_irout", 32'(bus.irout), 32'd0);
      check("rst_opcode", 32'(opcode), 32'd0);
      reset = 1'b0;

      // 1: zero-wait NOP stream, fetch every third cycle
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         check("t1_fetch", 32'(bus.fetch), 32'((k % 3) == 1));
         check("t1_pcout", 32'(bus.pcout), 32'((k + 1) / 3));
         if ((k % 3) == 1) begin
            pc_model = pc_model + 28'd1;
            e.pc = pc_model;
            e.ir = 32'h0;
            sb_q.push_back(e);
         end else if ((k % 3) == 2) begin
            decode_pop();
         end else begin
            check("t1_ir_valid_low", 32'(ir_valid), 32'd0);
         end
      end
      bus.mem_ready = 1'b0;

      // 2: JMP to the top address, then a NOP wraps the PC to zero
      wait_fetch();
      fetch_instr(32'h8FFF_FFFF, 1);
      tick();
      check("t2_exec_ctrl", {29'd0, bus.fetch, bus.mem_req, ir_valid}, 32'd0);
      pc_model = 28'hFFF_FFFF;
      wait_fetch();
      fetch_instr(32'h0000_0000, 0);
      check("t2_wrap", 32'(bus.pcout), 32'd0);
      wait_fetch();

      // 3: JMP ignores a simultaneous branch; unknown opcode takes a branch
      fetch_instr(32'h8123_4567, 0);
      branch_en     = 1'b1;
      branch_target = 28'h0AB_CDEF;
      tick();
      tick();
      branch_en = 1'b0;
      pc_model  = 28'h123_4567;
      check("t3_jmp_pc", 32'(bus.pcout), 32'h0123_4567);
      check("t3_fetch", 32'(bus.fetch), 32'd1);
      fetch_instr(32'h5000_0010, 0);
      tick();
      branch_en = 1'b1;
      tick();
      branch_en = 1'b0;
      pc_model  = 28'h0AB_CDEF;
      check("t3_branch_pc", 32'(bus.pcout), 32'h00AB_CDEF);

      // 4: STORE with two wait cycles, then zero-wait LOAD
      fetch_instr(32'h2000_00AA, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_store_ctrl", {29'd0, bus.fetch, bus.mem_req, bus.mem_we}, 32'd3);
      end
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      check("t4_back_fetch", {29'd0, bus.fetch, bus.mem_req, bus.mem_we}, 32'd6);
      fetch_instr(32'h1000_0001, 0);
      bus.mem_ready = 1'b1;
      tick();
      check("t4_load_ctrl", {29'd0, bus.fetch, bus.mem_req, bus.mem_we}, 32'd2);
      tick();
      bus.mem_ready = 1'b0;
      check("t4_load_done", 32'(bus.fetch), 32'd1);

      // 5: stall in FETCH with memory ready
      stall         = 1'b1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h0000_0055;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_stall_ctrl", {29'd0, bus.fetch, bus.mem_req, ir_valid}, 32'd6);
         check("t5_stall_pc", 32'(bus.pcout), 32'(pc_model));
         check("t5_stall_ir", 32'(bus.irout), 32'h0000_0001);
      end
      stall = 1'b0;
      fetch_instr(32'h0000_0055, 0);
      wait_fetch();

      // 6: HALT is absorbing; reset mid-FETCH drops everything at once
      fetch_instr(32'hF000_0000, 0);
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         branch_en = ~branch_en;
         check("t6_halt_ctrl", {29'd0, halted, bus.fetch, bus.mem_req}, 32'd4);
         check("t6_halt_pc", 32'(bus.pcout), 32'(pc_model));
      end
      branch_en     = 1'b0;
      bus.mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      check("t6_halt_reset", {30'd0, halted, bus.fetch}, 32'd0);
      check("t6_halt_reset_pc", 32'(bus.pcout), 32'd0);
      tick();
      reset    = 1'b0;
      pc_model = 28'h0;
      wait_fetch();
      fetch_instr(32'h8000_0123, 0);
      tick();
      tick();
      pc_model = 28'h000_0123;
      check("t6_pre_reset_pc", 32'(bus.pcout), 32'h0000_0123);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h0000_0777;
      #2;
      reset = 1'b1;
      #1;
      check("t6_abort_ctrl", {29'd0, bus.fetch, bus.mem_req, ir_valid}, 32'd0);
      check("t6_abort_pc", 32'(bus.pcout), 32'd0);
      check("t6_abort_ir", {bus.irout, opcode}, 32'd0);
      tick();
      reset         = 1'b0;
      bus.mem_ready = 1'b0;
      tick();
      check("t6_restart", {bus.pcout, 3'd0, bus.fetch}, 32'd1);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
